// File: rtl/tcm_sram.sv
// Tightly-coupled single-port SRAM with byte-lane writes, 1- or 2-cycle pipelined reads and a zeroing sweep after reset.
// Optional per-lane even parity with a perr flag when TCM_SRAM_PARITY_EN is defined.
module tcm_sram #(
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 16384,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned INIT_ZERO = 1,
  localparam int unsigned NB       = DW / 8,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [NB-1:0] be,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wd,
  output logic          rdy,
  output logic          rvalid,
  output logic [DW-1:0] rd
`ifdef TCM_SRAM_PARITY_EN
  ,
  output logic          perr
`endif
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          init_we_c;
  logic          rd_acc_c;
  logic          wr_acc_c;
  logic [DW-1:0] mem [DEPTH];

  assign rd_acc_c = en & rdy & ~we;
  assign wr_acc_c = en & rdy & we;

  // Controller: sweep zeros through the array, then open for requests
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we_c = 1'b0;
    case (state_q)
      S_INIT: begin
        if (INIT_ZERO == 0) begin
          state_d = S_RUN;
        end else begin
          init_we_c = ~rst;
          cnt_d     = cnt_q + (AW+1)'(1);
          if (cnt_q == (AW+1)'(DEPTH - 1)) state_d = S_RUN;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      rdy     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy     <= (state_d == S_RUN);
    end
  end

  // Array write port: sweep has priority, but requests are never accepted during INIT anyway
  always_ff @(posedge clk) begin
    if (init_we_c) begin
      mem[cnt_q[AW-1:0]] <= '0;
    end else if (wr_acc_c) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wd[8*k +: 8];
      end
    end
  end

`ifdef TCM_SRAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] src_par_c;

  function automatic logic [NB-1:0] lane_par(input logic [DW-1:0] d);
    lane_par = '0;
    for (int unsigned k = 0; k < NB; k++) lane_par[k] = ^d[8*k +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (init_we_c) begin
      par_mem[cnt_q[AW-1:0]] <= '0;
    end else if (wr_acc_c) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (be[k]) par_mem[addr][k] <= ^wd[8*k +: 8];
      end
    end
  end
`endif

  // Source of the output stage: the array itself (1 cycle) or an extra pipeline register (2 cycles)
  logic          src_vld_c;
  logic [DW-1:0] src_dat_c;

  if (READ_LAT == 1) begin : g_lat1
    assign src_vld_c = rd_acc_c;
    assign src_dat_c = mem[addr];
`ifdef TCM_SRAM_PARITY_EN
    assign src_par_c = par_mem[addr];
`endif
  end else begin : g_lat2
    logic          v1_q;
    logic [DW-1:0] d1_q;
`ifdef TCM_SRAM_PARITY_EN
    logic [NB-1:0] p1_q;
`endif
    always_ff @(posedge clk) begin
      if (rst) v1_q <= 1'b0;
      else     v1_q <= rd_acc_c;
      if (rd_acc_c) begin
        d1_q <= mem[addr];
`ifdef TCM_SRAM_PARITY_EN
        p1_q <= par_mem[addr];
`endif
      end
    end
    assign src_vld_c = v1_q;
    assign src_dat_c = d1_q;
`ifdef TCM_SRAM_PARITY_EN
    assign src_par_c = p1_q;
`endif
  end

  // Output stage: rd only moves with rvalid so it holds the last read value
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rd     <= '0;
`ifdef TCM_SRAM_PARITY_EN
      perr   <= 1'b0;
`endif
    end else begin
      rvalid <= src_vld_c;
      if (src_vld_c) rd <= src_dat_c;
`ifdef TCM_SRAM_PARITY_EN
      perr   <= src_vld_c & (|(lane_par(src_dat_c) ^ src_par_c));
`endif
    end
  end

endmodule

// File: tb/tb_tcm_sram.sv
// Directed bench for tcm_sram: one READ_LAT=1 and one READ_LAT=2 instance driven in lockstep.
module tb_tcm_sram;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk, rst, en, we;
  logic [NB-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;
  logic          rdy1, rv1, rdy2, rv2;
  logic [DW-1:0] rd1, rd2;
`ifdef TCM_SRAM_PARITY_EN
  logic          perr1, perr2;
`endif

  int n_chk = 0;
  int n_bad = 0;

  tcm_sram #(.DW(DW), .DEPTH(DEPTH), .READ_LAT(1), .INIT_ZERO(1)) u_l1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .wd(wd),
    .rdy(rdy1), .rvalid(rv1), .rd(rd1)
`ifdef TCM_SRAM_PARITY_EN
    , .perr(perr1)
`endif
  );

  tcm_sram #(.DW(DW), .DEPTH(DEPTH), .READ_LAT(2), .INIT_ZERO(1)) u_l2 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .wd(wd),
    .rdy(rdy2), .rvalid(rv2), .rd(rd2)
`ifdef TCM_SRAM_PARITY_EN
    , .perr(perr2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; we = 1'b0; be = '0; addr = '0; wd = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
    en = 1'b1; we = 1'b1; addr = a; wd = d; be = b;
    step();
    idle();
  endtask

  // Single read: LAT1 responds after the accept edge, LAT2 one edge later
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    en = 1'b1; we = 1'b0; addr = a;
    step();
    idle();
    chk({tag, "_rv1"}, 32'(rv1), 32'd1);
    chk({tag, "_rd1"}, rd1, exp);
    chk({tag, "_rv2_early"}, 32'(rv2), 32'd0);
`ifdef TCM_SRAM_PARITY_EN
    chk({tag, "_perr1"}, 32'(perr1), 32'd0);
`endif
    step();
    chk({tag, "_rv1_off"}, 32'(rv1), 32'd0);
    chk({tag, "_rv2"}, 32'(rv2), 32'd1);
    chk({tag, "_rd2"}, rd2, exp);
`ifdef TCM_SRAM_PARITY_EN
    chk({tag, "_perr2"}, 32'(perr2), 32'd0);
`endif
  endtask

  // Count cycles from the reset edge until rdy rises, bounded
  task automatic init_wait(input string tag);
    int n;
    n = 0;
    while (!rdy1 && n < 40) begin
      step();
      n++;
    end
    idle();
    chk({tag, "_len"}, 32'(n), 32'd16);
    chk({tag, "_rdy2"}, 32'(rdy2), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] e2 [5];
    e2 = '{32'hDE22BE44, 32'd1, 32'd2, 32'd3, 32'd3};
    rst = 1'b1;
    idle();
    step();
    chk("rst_rdy1", 32'(rdy1), 32'd0);
    chk("rst_rv1",  32'(rv1),  32'd0);
    chk("rst_rd1",  rd1,       32'd0);
    chk("rst_rdy2", 32'(rdy2), 32'd0);
    chk("rst_rv2",  32'(rv2),  32'd0);
    chk("rst_rd2",  rd2,       32'd0);

    // Writes attempted during INIT must be ignored
    rst = 1'b0;
    en = 1'b1; we = 1'b1; addr = '0; wd = 32'hFFFFFFFF; be = '1;
    init_wait("init");
    for (int a = 0; a < int'(DEPTH); a++) rd_chk("clr", AW'(a), 32'd0);

    // Byte-lane merge and be=0 no-op
    wr(3, 32'hDEADBEEF, 4'b1111);
    wr(3, 32'h11223344, 4'b0101);
    rd_chk("merge", 3, 32'hDE22BE44);
    wr(3, 32'h00000000, 4'b0000);
    rd_chk("be0", 3, 32'hDE22BE44);

    // Back-to-back reads, mem[n]=n
    wr(1, 32'd1, 4'hF);
    wr(2, 32'd2, 4'hF);
    wr(3, 32'd3, 4'hF);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        en = 1'b1; we = 1'b0; addr = AW'(i + 1);
      end else begin
        idle();
      end
      step();
      chk("b2b_rv1", 32'(rv1), (i < 3) ? 32'd1 : 32'd0);
      chk("b2b_rd1", rd1, (i < 3) ? 32'(i + 1) : 32'd3);
      chk("b2b_rv2", 32'(rv2), (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
      chk("b2b_rd2", rd2, e2[i]);
    end

    // Read in flight while the same word is rewritten, then read again
    wr(5, 32'hAAAA5555, 4'hF);
    en = 1'b1; we = 1'b0; addr = 5;
    step();
    chk("cf_rv1_a", 32'(rv1), 32'd1);
    chk("cf_rd1_a", rd1, 32'hAAAA5555);
    en = 1'b1; we = 1'b1; addr = 5; wd = 32'h12345678; be = 4'hF;
    step();
    chk("cf_rv1_wr", 32'(rv1), 32'd0);
    chk("cf_rd1_hold", rd1, 32'hAAAA5555);
    chk("cf_rv2_a", 32'(rv2), 32'd1);
    chk("cf_rd2_a", rd2, 32'hAAAA5555);
    en = 1'b1; we = 1'b0; addr = 5;
    step();
    idle();
    chk("cf_rv1_b", 32'(rv1), 32'd1);
    chk("cf_rd1_b", rd1, 32'h12345678);
    chk("cf_rv2_wr", 32'(rv2), 32'd0);
    step();
    chk("cf_rv2_b", 32'(rv2), 32'd1);
    chk("cf_rd2_b", rd2, 32'h12345678);

`ifdef TCM_SRAM_PARITY_EN
    wr(7, 32'h000000FF, 4'hF);
    u_l1.par_mem[7][0] = ~u_l1.par_mem[7][0];
    u_l2.par_mem[7][0] = ~u_l2.par_mem[7][0];
    en = 1'b1; we = 1'b0; addr = 7;
    step();
    idle();
    chk("par_rv1", 32'(rv1), 32'd1);
    chk("par_perr1", 32'(perr1), 32'd1);
    step();
    chk("par_rv2", 32'(rv2), 32'd1);
    chk("par_perr2", 32'(perr2), 32'd1);
    rd_chk("par_clean", 5, 32'h12345678);
`endif

    // Reset with a read in flight drops it
    en = 1'b1; we = 1'b0; addr = 5;
    step();
    idle();
    rst = 1'b1;
    step();
    chk("rif_rv2", 32'(rv2), 32'd0);
    chk("rif_rv1", 32'(rv1), 32'd0);
    chk("rif_rd1", rd1, 32'd0);
    chk("rif_rd2", rd2, 32'd0);
    chk("rif_rdy", 32'(rdy1), 32'd0);

    // Reset pulse mid-sweep restarts the full sweep
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    init_wait("restart");
    rd_chk("rs_a3", 3, 32'd0);
    rd_chk("rs_a5", 5, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/tcm_sram.md
TCM_SRAM -- requirements
Module: tcm_sram

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits; multiple of 8, range 8..128.
REQ-002 SHALL have parameter DEPTH, default 16384, number of words; power of two, range 16..65536.
REQ-003 SHALL have parameter READ_LAT, default 1, read latency in cycles; legal values 1 and 2.
REQ-004 SHALL have parameter INIT_ZERO, default 1; 1 = clear the array after reset, 0 = skip clearing.
REQ-005 SHALL have derived constants NB = DW/8 (byte lanes) and AW = log2(DEPTH).
REQ-006 clk  in  1  single clock; all logic on its rising edge; one clock; reset is synchronous and active-high.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 en  in  1  request valid.
REQ-009 we  in  1  1 = write, 0 = read; sampled with en.
REQ-010 be  in  NB  per-lane byte write enable; ignored on reads.
REQ-011 addr  in  AW  word address.
REQ-012 wd  in  DW  write data; lane k = wd[8k+7:8k].
REQ-013 rdy  out  1  block accepts requests.
REQ-014 rvalid  out  1  one-cycle pulse marking rd valid.
REQ-015 rd  out  DW  read data; holds its value between reads.
REQ-016 perr  out  1  parity error flag; present only with TCM_SRAM_PARITY_EN.

Function
REQ-017 SHALL accept a request in any cycle where en=1 and rdy=1; en while rdy=0 SHALL be ignored with no side effects.
REQ-018 Accepted write SHALL update only lanes with be[k]=1 at the end of the accept cycle; be=0 SHALL be a legal no-op.
REQ-019 Accepted read SHALL assert rvalid and present rd exactly READ_LAT cycles after the accept edge.
REQ-020 Fully pipelined: one request per cycle sustained; back-to-back reads SHALL give back-to-back rvalid pulses in order.
REQ-021 Read to an address written in the same accept cycle SHALL return the old data; a read in the next cycle SHALL return the new data.
REQ-022 rd SHALL change only when rvalid=1; otherwise it holds the last read value (0 after reset).
REQ-023 Controller FSM states: INIT and RUN.
  - INIT: rdy=0; internal counter steps 0..DEPTH-1 writing all-zero words, one per cycle; after DEPTH-1 is written, next state RUN.
  - RUN: rdy=1.
REQ-024 With INIT_ZERO=0, the FSM SHALL enter RUN on the first cycle after reset, and array contents are undefined.
REQ-025 The address counter SHALL be AW+1 bits wide so that DEPTH terminates without wrap-around aliasing.
REQ-026 Writes SHALL have no response pulse; rvalid SHALL never assert for a write.

Reset
REQ-027 While rst=1: state=INIT, counter=0, rdy=0, rvalid=0, rd=0, perr=0, read pipeline stages invalidated.
REQ-028 rst asserted during INIT SHALL restart the clear at word 0.
REQ-029 rst asserted with reads in flight SHALL drop them; no rvalid for them after reset.
REQ-030 Array contents are not reset directly; only the INIT sweep clears them.

Configuration
REQ-031 Macro TCM_SRAM_PARITY_EN defined:
  - one even-parity bit stored per byte lane, written on every lane write and by the INIT sweep;
  - on each rvalid, parity is recomputed per lane; perr=1 in that same cycle if any lane mismatches, otherwise perr=0;
  - perr is registered in step with rd.
REQ-032 Macro TCM_SRAM_PARITY_EN undefined: no parity storage, no perr port, identical latency and data behaviour.

Verification
REQ-033 rst 1 cycle, INIT_ZERO=1, DEPTH=16 -> rdy=0 for exactly 16 cycles, then rdy=1; reads of addr 0..15 return 0x00000000.
REQ-034 Write addr=3 wd=0xDEADBEEF be=4'b1111, then write addr=3 wd=0x11223344 be=4'b0101, then read addr=3 -> rd=0xDE22BE44 with rvalid READ_LAT cycles after the read accept.
REQ-035 READ_LAT=2, reads of addr 1,2,3 in consecutive cycles (mem[n]=n) -> rvalid high 3 consecutive cycles starting 2 cycles after the first accept, rd=1,2,3.
REQ-036 Same-cycle conflict: mem[5]=0xAAAA5555, then write 0x12345678 to addr 5 and read addr 5 accepted in the same cycle (write port and read pipeline sampling together), then read addr 5 next cycle -> rd=0xAAAA5555 then 0x12345678.
REQ-037 en=1 during INIT with we=1 addr=0 wd=0xFFFFFFFF -> ignored; after RUN, a read of addr 0 returns 0; rst pulse in cycle 5 of INIT -> the full 16-cycle sweep restarts.
REQ-038 With TCM_SRAM_PARITY_EN: write 0x000000FF, flip stored parity of lane 0 by force, read -> perr=1 on the rvalid cycle; a clean read -> perr=0.
